// File: rtl/bomberman_pkg.sv
// Shared encodings for the player-motion block and its colliders.
package bomberman_pkg;

   // Facing / request encodings as seen on the dir output.
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // Tiles are 16 px square.
   localparam int unsigned TILE_LOG2 = 4;

   typedef enum logic {ST_IDLE, ST_WALK} state_t;

   // The blocked vector is ordered [3]=up..[0]=right, the reverse of the dir encoding.
   function automatic logic [1:0] blk_idx(input logic [1:0] d);
      return 2'd3 - d;
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running prescaler producing a one-clock movement tick every STEP_DIV clocks.
module move_tick_gen #(
   parameter int unsigned STEP_DIV = 1000000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Count 0..STEP_DIV-1, wrapping on the tick cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/bomberman_motion.sv
// Tile-committed player movement: arbitrates buttons, honours walls and arena edges on
// grid-aligned positions, and steps the sprite 1 px per movement tick.
module bomberman_motion
   import bomberman_pkg::*;
#(
   parameter logic [9:0]  X_MIN    = 10'd143,
   parameter logic [9:0]  Y_MIN    = 10'd33,
   parameter logic [9:0]  X_MAX    = 10'd767,
   parameter logic [9:0]  Y_MAX    = 10'd497,
   parameter logic [9:0]  START_X  = 10'd143,
   parameter logic [9:0]  START_Y  = 10'd33,
   parameter int unsigned STEP_DIV = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic [3:0] bomberman_blocked,
   output logic [9:0] b_x,
   output logic [9:0] b_y,
   output logic [1:0] dir,
   output logic       walking,
   output logic [1:0] anim_frame
);

   logic       tick;
   state_t     state_q, state_d;
   logic [1:0] dir_q, dir_d;
   logic [9:0] b_x_q, b_y_q;
   logic [1:0] anim_q, px_cnt_q;
   logic       move;
   logic [1:0] move_dir;

   logic [9:0] off_x, off_y;
   logic       aligned;
   logic       req_valid;
   logic [1:0] req_dir;
   logic [3:0] edge_blk, eff_blk;
   logic       req_blk;

   move_tick_gen #(
      .STEP_DIV (STEP_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign off_x   = b_x_q - X_MIN;
   assign off_y   = b_y_q - Y_MIN;
   assign aligned = (off_x[TILE_LOG2-1:0] == '0) && (off_y[TILE_LOG2-1:0] == '0);

   // Arena edges in the same bit order as the collider flags.
   assign edge_blk = {(b_y_q == Y_MIN), (b_y_q == Y_MAX), (b_x_q == X_MIN), (b_x_q == X_MAX)};
   assign eff_blk  = bomberman_blocked | edge_blk;

   // Fixed-priority request arbiter: up > down > left > right.
   always_comb begin
      req_valid = 1'b1;
      req_dir   = DIR_UP;
      if (btn_up)         req_dir = DIR_UP;
      else if (btn_down)  req_dir = DIR_DOWN;
      else if (btn_left)  req_dir = DIR_LEFT;
      else if (btn_right) req_dir = DIR_RIGHT;
      else                req_valid = 1'b0;
   end

   assign req_blk = eff_blk[blk_idx(req_dir)];

   // Next-state, facing and move decision; only tick cycles change anything.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      move     = 1'b0;
      move_dir = dir_q;
      if (tick) begin
         if (state_q == ST_WALK && !aligned) begin
            // Mid-tile: finish the tile regardless of inputs.
            move = 1'b1;
         end else if (req_valid) begin
            dir_d = req_dir;
            if (!req_blk) begin
               state_d  = ST_WALK;
               move     = 1'b1;
               move_dir = req_dir;
            end else begin
               state_d = ST_IDLE;
            end
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // FSM state and facing registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_DOWN;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
      end
   end

   // Position registers; edge checks upstream guarantee no wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_x_q <= START_X;
         b_y_q <= START_Y;
      end else if (move) begin
         unique case (move_dir)
            DIR_UP:    b_y_q <= b_y_q - 10'd1;
            DIR_DOWN:  b_y_q <= b_y_q + 10'd1;
            DIR_LEFT:  b_x_q <= b_x_q - 10'd1;
            DIR_RIGHT: b_x_q <= b_x_q + 10'd1;
         endcase
      end
   end

   // Walk-cycle frame advances every 4 px moved; cleared when the walk ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         anim_q   <= 2'd0;
         px_cnt_q <= 2'd0;
      end else if (state_q == ST_WALK && state_d == ST_IDLE) begin
         anim_q   <= 2'd0;
         px_cnt_q <= 2'd0;
      end else if (move) begin
         px_cnt_q <= px_cnt_q + 2'd1;
         if (px_cnt_q == 2'd3) anim_q <= anim_q + 2'd1;
      end
   end

   assign b_x        = b_x_q;
   assign b_y        = b_y_q;
   assign dir        = dir_q;
   assign walking    = (state_q == ST_WALK);
   assign anim_frame = anim_q;

endmodule

// File: tb/tb_bomberman_motion.sv
// Directed bench for bomberman_motion with a 4-clock movement tick.
module tb_bomberman_motion;

   localparam logic [3:0] B_NONE  = 4'b0000;
   localparam logic [3:0] B_UP    = 4'b1000;
   localparam logic [3:0] B_DOWN  = 4'b0100;
   localparam logic [3:0] B_LEFT  = 4'b0010;
   localparam logic [3:0] B_RIGHT = 4'b0001;

   logic       clk;
   logic       reset;
   logic       btn_up, btn_down, btn_left, btn_right;
   logic [3:0] bomberman_blocked;
   logic [9:0] b_x, b_y;
   logic [1:0] dir;
   logic       walking;
   logic [1:0] anim_frame;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] btn;   // {up,down,left,right}
      logic [3:0] blk;
      int         x;
      int         y;
      int         d;
      int         walk;
      int         anim;
   } vec_t;

   vec_t vecs[$];

   bomberman_motion #(
      .STEP_DIV (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .btn_up            (btn_up),
      .btn_down          (btn_down),
      .btn_left          (btn_left),
      .btn_right         (btn_right),
      .bomberman_blocked (bomberman_blocked),
      .b_x               (b_x),
      .b_y               (b_y),
      .dir               (dir),
      .walking           (walking),
      .anim_frame        (anim_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int x, input int y, input int d,
                            input int walk, input int anim);
      check({tag, " b_x"}, int'(b_x), x);
      check({tag, " b_y"}, int'(b_y), y);
      check({tag, " dir"}, int'(dir), d);
      check({tag, " walking"}, int'(walking), walk);
      check({tag, " anim_frame"}, int'(anim_frame), anim);
   endtask

   task automatic set_in(input logic [3:0] btn, input logic [3:0] blk);
      {btn_up, btn_down, btn_left, btn_right} = btn;
      bomberman_blocked = blk;
   endtask

   // One movement-tick period; ends 1 time unit after the tick edge.
   task automatic step();
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Hold reset for 3 clocks and release on a falling edge.
   task automatic do_reset();
      reset = 1'b0;
      set_in(B_NONE, 4'b0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_all("reset", 143, 33, 1, 0, 0);
   endtask

   function automatic void add(input logic [3:0] btn, input logic [3:0] blk, input int x,
                               input int y, input int d, input int walk, input int anim);
      vec_t v;
      v.btn = btn; v.blk = blk; v.x = x; v.y = y; v.d = d; v.walk = walk; v.anim = anim;
      vecs.push_back(v);
   endfunction

   initial begin
      // Continues from the first hand-driven tick (b_x=144).
      for (int k = 2; k <= 7; k++)  add(B_RIGHT, 4'b0000, 143 + k, 33, 3, 1, (k / 4) % 4);
      // Released at 150: tile still completes to 159; anim 3 at 155.
      for (int k = 8; k <= 16; k++) add(B_NONE, 4'b0000, 143 + k, 33, 3, 1, (k / 4) % 4);
      add(B_NONE,  4'b0000, 159, 33, 3, 0, 0);   // aligned, no request -> IDLE
      add(B_RIGHT, 4'b0001, 159, 33, 3, 0, 0);   // collider blocks right: turn in place
      add(B_RIGHT, 4'b0000, 160, 33, 3, 1, 0);   // cleared: move
      add(B_LEFT,  4'b0000, 161, 33, 3, 1, 0);   // reversal mid-tile ignored
      add(B_UP,    4'b0000, 162, 33, 3, 1, 0);
      for (int x = 163; x <= 175; x++) add(B_NONE, 4'b0000, x, 33, 3, 1, ((x - 159) / 4) % 4);
      add(B_DOWN,  4'b0000, 175, 34, 1, 1, 0);   // aligned turn while walking
      add(B_NONE,  4'b0000, 175, 35, 1, 1, 0);

      // Reset state and first-tick latency.
      set_in(B_NONE, 4'b0000);
      do_reset();
      btn_right = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("no tick before 4th clk b_x", int'(b_x), 143);
      @(posedge clk);
      #1;
      check_all("first tick", 144, 33, 3, 1, 0);

      foreach (vecs[i]) begin
         set_in(vecs[i].btn, vecs[i].blk);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].walk,
                   vecs[i].anim);
      end

      // Up+left at origin: up wins but is edge-blocked; then left is edge-blocked.
      do_reset();
      set_in(B_UP | B_LEFT, 4'b0000);
      step();
      check_all("up+left", 143, 33, 0, 0, 0);
      set_in(B_LEFT, 4'b0000);
      step();
      check_all("left edge", 143, 33, 2, 0, 0);
      set_in(B_DOWN, 4'b0100);
      step();
      check_all("down blocked", 143, 33, 1, 0, 0);
      set_in(B_DOWN, 4'b0000);
      step();
      check_all("down move", 143, 34, 1, 1, 0);

      // Asynchronous reset mid-tile.
      do_reset();
      set_in(B_RIGHT, 4'b0000);
      repeat (7) step();
      check_all("pre-reset", 150, 33, 3, 1, 1);
      reset = 1'b0;
      #1;
      check_all("async reset", 143, 33, 1, 0, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      check_all("after reset tick", 144, 33, 3, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
